pac_wrr_arb_n: RTL and testbench

//  N-way weighted round-robin arbiter core with per-grant beat credits, starvation aging and

---
 rtl/pac_rr_pkg.sv | 19 +
 rtl/pac_rr_pick.sv | 26 ++
 rtl/pac_wrr_arb_n.sv | 127 ++++++++++++
 tb/tb_pac_wrr_arb_n.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pac_rr_pkg.sv
// Shared types and defaults for the PAC weighted round-robin arbiter.
package pac_rr_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StGrant
   } arb_state_e;

   localparam int unsigned DefNReq      = 4;
   localparam int unsigned DefWWidth    = 3;
   localparam int unsigned DefAgeWidth  = 4;
   localparam int unsigned DefAgeThresh = 8;

   // Index width that stays legal for the smallest supported arbiter.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pac_rr_pick.sv
// Rotating-priority find-first: first set bit of vec searching from ptr+1, wrapping.
module pac_rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  vec,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         int unsigned cand;
         cand = 32'(ptr) + k;
         if (cand >= N) cand = cand - N;
         if (!found && vec[cand]) begin
            found = 1'b1;
            idx   = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/pac_wrr_arb_n.sv
// N-way weighted round-robin arbiter with beat credits, starvation aging and
// shadow/commit weight programming.
module pac_wrr_arb_n
   import pac_rr_pkg::*;
#(
   parameter int unsigned N_REQ      = DefNReq,
   parameter int unsigned W_WIDTH    = DefWWidth,
   parameter int unsigned AGE_WIDTH  = DefAgeWidth,
   parameter int unsigned AGE_THRESH = DefAgeThresh,
   localparam int unsigned IDX_W     = idx_width(N_REQ)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [N_REQ-1:0]         req_i,
   input  logic                     src_valid_i,
   input  logic                     sink_ready_i,
   input  logic [N_REQ*W_WIDTH-1:0] cfg_weight_i,
   input  logic                     cfg_commit_i,
   output logic [N_REQ*W_WIDTH-1:0] weight_o,
   output logic [N_REQ-1:0]         grant_o,
   output logic [IDX_W-1:0]         grant_idx_o,
   output logic                     busy_o,
   output logic [W_WIDTH-1:0]       credit_o,
   output logic                     aged_win_o
);

   arb_state_e           state_q;
   logic [IDX_W-1:0]     ptr_q;
   logic [N_REQ-1:0]     grant_q;
   logic [IDX_W-1:0]     grant_idx_q;
   logic [W_WIDTH-1:0]   credit_q;
   logic                 aged_win_q;
   logic [W_WIDTH-1:0]   weight_q [N_REQ];
   logic [AGE_WIDTH-1:0] age_q    [N_REQ];

   logic [N_REQ-1:0] elig, aged;
   logic             aged_found, elig_found;
   logic [IDX_W-1:0] aged_idx, elig_idx, win_idx;
   logic             beat, release_turn;

   always_comb begin
      elig = '0;
      aged = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         elig[k] = req_i[k] && (weight_q[k] != '0);
         aged[k] = elig[k] && (32'(age_q[k]) >= AGE_THRESH);
      end
   end

   pac_rr_pick #(.N(N_REQ), .IW(IDX_W)) u_pick_aged (
      .vec   (aged),
      .ptr   (ptr_q),
      .found (aged_found),
      .idx   (aged_idx)
   );

   pac_rr_pick #(.N(N_REQ), .IW(IDX_W)) u_pick_elig (
      .vec   (elig),
      .ptr   (ptr_q),
      .found (elig_found),
      .idx   (elig_idx)
   );

   assign win_idx      = aged_found ? aged_idx : elig_idx;
   assign beat         = (state_q == StGrant) && src_valid_i && sink_ready_i;
   assign release_turn = (beat && credit_q == W_WIDTH'(1)) || !req_i[grant_idx_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         ptr_q       <= IDX_W'(N_REQ - 1);
         grant_q     <= '0;
         grant_idx_q <= '0;
         credit_q    <= '0;
         aged_win_q  <= 1'b0;
         for (int unsigned k = 0; k < N_REQ; k++) begin
            weight_q[k] <= W_WIDTH'(1);
            age_q[k]    <= '0;
         end
      end else begin
         aged_win_q <= 1'b0;
         // Grant load below reads weight_q before this update lands.
         if (cfg_commit_i) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
               weight_q[k] <= cfg_weight_i[k*W_WIDTH +: W_WIDTH];
            end
         end
         unique case (state_q)
            StIdle: begin
               if (elig_found) begin
                  state_q     <= StGrant;
                  grant_q     <= N_REQ'(1) << win_idx;
                  grant_idx_q <= win_idx;
                  credit_q    <= weight_q[win_idx];
                  aged_win_q  <= aged_found;
                  for (int unsigned k = 0; k < N_REQ; k++) begin
                     if (elig[k]) begin
                        if (k == 32'(win_idx))  age_q[k] <= '0;
                        else if (age_q[k] != '1) age_q[k] <= age_q[k] + 1'b1;
                     end
                  end
               end
            end
            StGrant: begin
               if (beat && credit_q != '0) credit_q <= credit_q - 1'b1;
               if (release_turn) begin
                  state_q <= StIdle;
                  grant_q <= '0;
                  ptr_q   <= grant_idx_q;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   for (genvar k = 0; k < N_REQ; k++) begin : g_weight_out
      assign weight_o[k*W_WIDTH +: W_WIDTH] = weight_q[k];
   end

   assign grant_o     = grant_q;
   assign grant_idx_o = grant_idx_q;
   assign busy_o      = (state_q == StGrant);
   assign credit_o    = credit_q;
   assign aged_win_o  = aged_win_q;

endmodule

// File: tb/tb_pac_wrr_arb_n.sv
// Directed self-checking bench for pac_wrr_arb_n; a second instance uses a low
// aging threshold for the starvation scenario.
module tb_pac_wrr_arb_n;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic        valid, ready;
   logic [11:0] cfg_weight;
   logic        commit;

   logic [11:0] weight, a2_weight;
   logic [3:0]  grant, a2_grant;
   logic [1:0]  gidx, a2_gidx;
   logic        busy, a2_busy;
   logic [2:0]  credit, a2_credit;
   logic        aged_win, a2_aged_win;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pac_wrr_arb_n #(.N_REQ(4), .W_WIDTH(3), .AGE_WIDTH(4), .AGE_THRESH(8)) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_i        (req),
      .src_valid_i  (valid),
      .sink_ready_i (ready),
      .cfg_weight_i (cfg_weight),
      .cfg_commit_i (commit),
      .weight_o     (weight),
      .grant_o      (grant),
      .grant_idx_o  (gidx),
      .busy_o       (busy),
      .credit_o     (credit),
      .aged_win_o   (aged_win)
   );

   pac_wrr_arb_n #(.N_REQ(4), .W_WIDTH(3), .AGE_WIDTH(4), .AGE_THRESH(2)) u_dut_age (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_i        (req),
      .src_valid_i  (valid),
      .sink_ready_i (ready),
      .cfg_weight_i (cfg_weight),
      .cfg_commit_i (commit),
      .weight_o     (a2_weight),
      .grant_o      (a2_grant),
      .grant_idx_o  (a2_gidx),
      .busy_o       (a2_busy),
      .credit_o     (a2_credit),
      .aged_win_o   (a2_aged_win)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned wts[4];
      logic        r_seq[5];
      int unsigned cr_seq[5];
      int unsigned own_seq[4];
      logic        agd_seq[4];
      wts     = '{1, 2, 3, 1};
      r_seq   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      cr_seq  = '{2, 2, 1, 1, 0};
      own_seq = '{2, 3, 0, 1};
      agd_seq = '{1'b0, 1'b1, 1'b1, 1'b1};

      // Reset values
      rst_n = 1'b0; req = '0; valid = 1'b0; ready = 1'b0; cfg_weight = '0; commit = 1'b0;
      tick(); tick();
      check("rst_grant", grant, 0);
      check("rst_idx", gidx, 0);
      check("rst_busy", busy, 0);
      check("rst_credit", credit, 0);
      check("rst_aged", aged_win, 0);
      check("rst_weight", weight, 12'h249);
      rst_n = 1'b1;
      tick(); tick();
      check("idle_busy", busy, 0);
      check("idle_grant", grant, 0);

      // WRR order with weights {1,2,3,1}
      cfg_weight = 12'h2D1; commit = 1'b1;
      tick();
      commit = 1'b0;
      check("commit_weight", weight, 12'h2D1);
      req = 4'hF; valid = 1'b1; ready = 1'b1;
      for (int o = 0; o < 4; o++) begin
         tick();
         check("wrr_grant", grant, 32'(1 << o));
         check("wrr_idx", gidx, 32'(o));
         check("wrr_credit", credit, wts[o]);
         check("wrr_aged", aged_win, 0);
         for (int unsigned b = 1; b < wts[o]; b++) begin
            tick();
            check("wrr_burst_grant", grant, 32'(1 << o));
            check("wrr_burst_credit", credit, wts[o] - b);
         end
         tick();
         check("wrr_dead_grant", grant, 0);
         check("wrr_dead_busy", busy, 0);
      end
      req = '0;

      // Backpressure on owner 2, weight 3
      req = 4'b0100; ready = 1'b0;
      tick();
      check("bp_grant", grant, 4'b0100);
      check("bp_credit0", credit, 3);
      for (int i = 0; i < 5; i++) begin
         ready = r_seq[i];
         tick();
         check("bp_credit", credit, cr_seq[i]);
         check("bp_grant_hold", grant, (i == 4) ? 4'b0000 : 4'b0100);
      end
      req = '0; ready = 1'b1;

      // Early drop: owner 1 with weight 4 drops after one beat
      cfg_weight = 12'h2E1; commit = 1'b1;
      tick();
      commit = 1'b0;
      check("drop_weight", weight, 12'h2E1);
      req = 4'b0010; valid = 1'b1;
      tick();
      check("drop_grant", grant, 4'b0010);
      check("drop_credit0", credit, 4);
      tick();
      check("drop_credit1", credit, 3);
      req = 4'b1101; valid = 1'b0;
      tick();
      check("drop_release", grant, 0);
      check("drop_idx_hold", gidx, 1);
      check("drop_credit_hold", credit, 3);
      tick();
      check("drop_next_owner", grant, 4'b0100);
      check("drop_next_credit", credit, 3);
      req = '0;
      tick();
      check("drop_next_release", grant, 0);

      // Commit in the same cycle as a grant load
      cfg_weight = 12'hFFF; commit = 1'b1; req = 4'b1000;
      tick();
      commit = 1'b0;
      check("race_grant", grant, 4'b1000);
      check("race_credit_old", credit, 1);
      check("race_weight", weight, 12'hFFF);
      valid = 1'b1; ready = 1'b1;
      tick();
      check("race_release", grant, 0);
      tick();
      check("race_regrant", grant, 4'b1000);
      check("race_credit_new", credit, 7);
      req = '0;
      tick();
      check("race_drop_grant", grant, 0);
      check("race_drop_credit", credit, 6);

      // Aging with threshold 2 on the second instance
      rst_n = 1'b0; req = '0; valid = 1'b0;
      tick(); tick();
      check("age_rst_weight", a2_weight, 12'h249);
      rst_n = 1'b1;
      cfg_weight = 12'h248; commit = 1'b1;
      tick();
      commit = 1'b0;
      req = 4'hF; valid = 1'b1; ready = 1'b1;
      tick();
      check("age_first_grant", a2_grant, 4'b0010);
      check("age_first_aged", a2_aged_win, 0);
      cfg_weight = 12'h249; commit = 1'b1;
      tick();
      commit = 1'b0;
      check("age_first_dead", a2_grant, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("age_grant", a2_grant, 32'(1 << own_seq[i]));
         check("age_aged_win", a2_aged_win, agd_seq[i]);
         tick();
         check("age_dead_grant", a2_grant, 0);
         check("age_pulse_clear", a2_aged_win, 0);
      end
      req = '0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
